layer_output_serializer: RTL
============================

# layer_output_serializer

- Downstream stage of a fully connected layer.
- Captures the parallel outputs of all neurons in the layer in the cycle their `outvalid` pulses fire.
- Replays those outputs as a serial stream of one word per cycle, neuron 0 first, in the `myinput`/`myinputValid` format the next layer's neurons consume.
- Flags protocol faults: a new capture arriving while a stream is still in progress, and neuron valid pulses that are not simultaneous.

## Interface
Parameters:
- `numNeurons`, 30, number of neurons in the producing layer (≥2)
- `dataWidth`, 16, width of each neuron output word

Ports:
- `clk`  in  1  clock, all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `neuron_out`  in  numNeurons*dataWidth  concatenated neuron outputs; neuron k at bits [k*dataWidth +: dataWidth]
- `neuron_valid`  in  numNeurons  per-neuron `outvalid` pulses
- `data_out`  out  dataWidth  serial word to next layer (`myinput`)
- `data_valid`  out  1  serial word valid (`myinputValid`)
- `busy`  out  1  high while a stream is in progress
- `overrun`  out  1  sticky: a capture was lost
- `valid_mismatch`  out  1  sticky: a capture saw `neuron_valid` not all-ones

## Operation
- Capture event: `neuron_valid[0]` high at a rising edge.
  - All `numNeurons` words are latched into the holding buffer.
  - If `neuron_valid` ≠ all-ones in that cycle, `valid_mismatch` is set; the capture still proceeds.
- States: IDLE, SEND.
  - IDLE: `data_valid`=0, `busy`=0, `data_out`=0. On a capture event, latch the buffer, set index=0, go to SEND.
  - SEND: drive word[index] with `data_valid`=1 and `busy`=1, then increment index. After emitting word `numNeurons-1`, return to IDLE, or restart at index 0 if a capture is accepted (see below).
- Index counter width: $clog2(numNeurons); it never exceeds `numNeurons-1`.
- Back-to-back capture:
  - A capture event in the same cycle that word `numNeurons-1` is emitted is accepted in both configurations.
  - The buffer reloads, index goes to 0, and state stays SEND. The stream continues with no gap cycle.
- Capture during SEND (index < `numNeurons-1`): handled per Configuration.
- `overrun` and `valid_mismatch` clear only on reset.
- Reset asserted mid-stream:
  - All outputs go to 0 immediately (asynchronous), state goes to IDLE, and the buffer contents are discarded.
  - After reset deasserts, nothing is emitted until a new capture event.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `busy`=0, `overrun`=0, `valid_mismatch`=0.
- All outputs are registered.
- Latency: if the capture edge is cycle C, word k is valid in cycle C+1+k.
- The last word is valid in cycle C+numNeurons. `busy` falls in cycle C+numNeurons+1 unless a new capture is accepted.
- No backpressure: the consumer must accept one word per cycle while `data_valid`=1.
- Minimum capture spacing without loss is `numNeurons` cycles in the base configuration.

## Configuration
- `LAYER_SER_DBUF_EN` defined: a second holding buffer (shadow) is compiled in.
  - A capture during SEND at index < `numNeurons-1` is stored in the shadow buffer. `overrun` is not set.
  - After word `numNeurons-1`, the shadow is copied into the main buffer and streaming continues at index 0 with no gap.
  - A further capture while the shadow is already occupied is dropped and sets `overrun`.
  - A capture in the handoff cycle (word `numNeurons-1` emitted with the shadow occupied) goes into the shadow; the old shadow data moves to main.
- `LAYER_SER_DBUF_EN` undefined: no shadow buffer.
  - A capture during SEND at index < `numNeurons-1` is ignored, `overrun` is set, and the current stream completes unchanged.

## Test plan
Use `numNeurons`=4 and `dataWidth`=16 unless stated otherwise.
- Single capture with words 0x0001, 0x0002, 0x0003, 0x0004 and `neuron_valid`=4'hF at cycle C -> `data_valid` high in C+1..C+4 carrying 0x0001..0x0004 in order; `busy` low at C+5; both flags stay 0.
- Back-to-back: second capture (0x0A..0x0D) at cycle C+4 -> eight consecutive valid cycles C+1..C+8 with data 1,2,3,4,A,B,C,D; `overrun`=0.
- Capture at C+2 in the base configuration -> output remains 1,2,3,4 only and `overrun`=1 from C+3. With `LAYER_SER_DBUF_EN` -> eight consecutive words and `overrun`=0.
- With `LAYER_SER_DBUF_EN`, captures at C, C+1 and C+2 -> words from C and C+1 streamed back-to-back, the C+2 data dropped, `overrun`=1.
- `neuron_valid`=4'b0111 on capture -> stream proceeds normally and `valid_mismatch`=1, held until reset.
- Drive `rst` low during cycle C+2 of a stream -> `data_valid`, `data_out` and `busy` are 0 before the next edge; no words appear after release until a new capture.

Source files
------------

// File: rtl/layer_output_serializer.sv
// layer_output_serializer: latches all neuron outputs of a layer and replays them one word per cycle.
// Optional shadow buffer for gapless overlapping captures: define LAYER_SER_DBUF_EN.
module layer_output_serializer #(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [numNeurons*dataWidth-1:0] neuron_out,
    input  logic [numNeurons-1:0]           neuron_valid,
    output logic [dataWidth-1:0]            data_out,
    output logic                            data_valid,
    output logic                            busy,
    output logic                            overrun,
    output logic                            valid_mismatch
);

    localparam int                    IDX_W     = $clog2(numNeurons);
    localparam int                    VEC_W     = numNeurons * dataWidth;
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(numNeurons - 1);
    localparam logic [IDX_W-1:0]      ONE_IDX   = IDX_W'(1);
    localparam logic [IDX_W-1:0]      ZERO_IDX  = IDX_W'(0);
    localparam logic [numNeurons-1:0] ALL_VALID = {numNeurons{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t               state_r;
    logic [IDX_W-1:0]     idx_r;
    logic [VEC_W-1:0]     hold_r;

    logic                 cap_s;
    logic                 mismatch_s;
    logic                 last_s;
    logic                 load_s;
    logic                 go_idle_s;
    logic                 overrun_set_s;
    logic [IDX_W-1:0]     nxt_idx_s;
    logic [VEC_W-1:0]     load_vec_s;
    logic [dataWidth-1:0] nxt_word_s;

`ifdef LAYER_SER_DBUF_EN
    logic [VEC_W-1:0]     shadow_r;
    logic                 shadow_full_r;
    logic                 shadow_wr_s;
    logic                 shadow_clr_s;
`endif

    function automatic logic [dataWidth-1:0] word_at(input logic [VEC_W-1:0] vec,
                                                     input logic [IDX_W-1:0] idx);
        word_at = vec[int'(idx) * dataWidth +: dataWidth];
    endfunction

    // Decode capture events, next index and the load / drop / handoff decision.
    always_comb begin
        cap_s         = neuron_valid[0];
        mismatch_s    = cap_s && (neuron_valid != ALL_VALID);
        last_s        = (idx_r == LAST_IDX);
        nxt_idx_s     = last_s ? ZERO_IDX : (idx_r + ONE_IDX);
        nxt_word_s    = word_at(hold_r, nxt_idx_s);
        load_s        = 1'b0;
        load_vec_s    = neuron_out;
        go_idle_s     = 1'b0;
        overrun_set_s = 1'b0;
`ifdef LAYER_SER_DBUF_EN
        shadow_wr_s   = 1'b0;
        shadow_clr_s  = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (cap_s) begin
                    load_s = 1'b1;
                end else begin
                    go_idle_s = 1'b1;
                end
            end
            ST_SEND: begin
                if (!last_s) begin
`ifdef LAYER_SER_DBUF_EN
                    if (cap_s && shadow_full_r) begin
                        overrun_set_s = 1'b1;
                    end else begin
                        shadow_wr_s = cap_s;
                    end
`else
                    overrun_set_s = cap_s;
`endif
                end else begin
`ifdef LAYER_SER_DBUF_EN
                    // Handoff: pending shadow data streams next; a same-cycle capture refills the shadow.
                    if (shadow_full_r) begin
                        load_s       = 1'b1;
                        load_vec_s   = shadow_r;
                        shadow_wr_s  = cap_s;
                        shadow_clr_s = !cap_s;
                    end else if (cap_s) begin
                        load_s = 1'b1;
                    end else begin
                        go_idle_s = 1'b1;
                    end
`else
                    if (cap_s) begin
                        load_s = 1'b1;
                    end else begin
                        go_idle_s = 1'b1;
                    end
`endif
                end
            end
            default: begin
                go_idle_s = 1'b1;
            end
        endcase
    end

    // Stream state machine with registered serial outputs and sticky fault flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_IDLE;
            idx_r          <= ZERO_IDX;
            hold_r         <= {VEC_W{1'b0}};
            data_out       <= {dataWidth{1'b0}};
            data_valid     <= 1'b0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
            valid_mismatch <= 1'b0;
        end else begin
            overrun        <= overrun | overrun_set_s;
            valid_mismatch <= valid_mismatch | mismatch_s;
            if (load_s) begin
                state_r    <= ST_SEND;
                idx_r      <= ZERO_IDX;
                hold_r     <= load_vec_s;
                data_out   <= load_vec_s[dataWidth-1:0];
                data_valid <= 1'b1;
                busy       <= 1'b1;
            end else if (go_idle_s) begin
                state_r    <= ST_IDLE;
                idx_r      <= ZERO_IDX;
                data_out   <= {dataWidth{1'b0}};
                data_valid <= 1'b0;
                busy       <= 1'b0;
            end else begin
                state_r    <= ST_SEND;
                idx_r      <= nxt_idx_s;
                data_out   <= nxt_word_s;
                data_valid <= 1'b1;
                busy       <= 1'b1;
            end
        end
    end

`ifdef LAYER_SER_DBUF_EN
    // Shadow buffer holding one capture that arrived mid-stream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_r      <= {VEC_W{1'b0}};
            shadow_full_r <= 1'b0;
        end else begin
            if (shadow_wr_s) begin
                shadow_r      <= neuron_out;
                shadow_full_r <= 1'b1;
            end else if (shadow_clr_s) begin
                shadow_full_r <= 1'b0;
            end else begin
                shadow_full_r <= shadow_full_r;
            end
        end
    end
`endif

endmodule
